// File: rtl/fpu_uni_pack.sv
// Packs a unified-format FPALU result into IEEE-754 binary16 with round-to-nearest-even.
// Latency: 3 + n cycles from accept to out_valid, n = alignment shift cycles (0..21).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fpu_uni_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        din_uni_y_sgn,
  input  logic [5:0]  din_uni_y_exp,
  input  logic [21:0] din_uni_y_man_dn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dout_h,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inx
);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               sgn_q, sgn_d;
  logic [21:0]        m_q, m_d;
  logic signed [7:0]  e_q, e_d;
  logic               s_q, s_d;
  logic [15:0]        dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inx_q, inx_d;

  // Binary16-biased exponent of the incoming operand (e_u - 16).
  logic signed [7:0]  e_in;
  assign e_in = $signed({2'b00, din_uni_y_exp}) - 8'sd16;

  // Rounding datapath, evaluated on the aligned mantissa.
  logic [10:0]        f_pre;
  logic               g_bit;
  logic               t_bit;
  logic               rnd_up;
  logic [11:0]        f_inc;
  logic [10:0]        f_fin;
  logic signed [7:0]  e_fin;
  logic signed [7:0]  field;
  logic [15:0]        pack_h;
  logic               pack_ovf;
  logic               pack_unf;
  logic               pack_inx;

  // RNE rounding of M[21:11] with carry-out renormalisation and overflow to infinity.
  always_comb begin
    f_pre    = m_q[21:11];
    g_bit    = m_q[10];
    t_bit    = s_q | (|m_q[9:0]);
    rnd_up   = g_bit & (t_bit | f_pre[0]);
    f_inc    = {1'b0, f_pre} + {11'd0, rnd_up};
    f_fin    = f_inc[10:0];
    e_fin    = e_q;
    if (f_inc == 12'h800) begin
      f_fin = 11'h400;
      e_fin = e_q + 8'sd1;
    end
    field    = f_fin[10] ? e_fin : 8'sd0;
    pack_inx = g_bit | t_bit;
    pack_unf = ~m_q[21] & pack_inx;
    pack_ovf = 1'b0;
    pack_h   = {sgn_q, field[4:0], f_fin[9:0]};
    if (field >= 8'sd31) begin
      pack_h   = {sgn_q, 5'h1F, 10'h000};
      pack_ovf = 1'b1;
      pack_inx = 1'b1;
    end
  end

  // Next-state logic: accept, one shift per cycle in ALIGN, round, then hold until taken.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sgn_d       = sgn_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sgn_d      = din_uni_y_sgn;
          s_d        = 1'b0;
          if (din_uni_y_man_dn == 22'd0) begin
            m_d = 22'd0;
            e_d = 8'sd1;
          end else if (e_in < -8'sd11) begin
            // Far below half the smallest denormal: flush, remember it was nonzero.
            m_d = 22'd0;
            s_d = 1'b1;
            e_d = 8'sd1;
          end else begin
            m_d = din_uni_y_man_dn;
            e_d = e_in;
          end
          in_ready_d = 1'b0;
          state_d    = ALIGN;
        end
      end
      ALIGN: begin
        if (e_q < 8'sd1) begin
          m_d = m_q >> 1;
          s_d = s_q | m_q[0];
          e_d = e_q + 8'sd1;
        end else if ((m_q != 22'd0) && !m_q[21] && (e_q > 8'sd1)) begin
          m_d = m_q << 1;
          e_d = e_q - 8'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        dout_d      = pack_h;
        ovf_d       = pack_ovf;
        unf_d       = pack_unf;
        inx_d       = pack_inx;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sgn_q       <= 1'b0;
      m_q         <= 22'd0;
      e_q         <= 8'sd0;
      s_q         <= 1'b0;
      dout_q      <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sgn_q       <= sgn_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout_h    = dout_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inx  = inx_q;

endmodule

// File: tb/tb_fpu_uni_pack.sv
// Bench for fpu_uni_pack: directed operands, value-level binary16 model, per-cycle output monitor.
// Latency: checks out_valid arrives 3 + n cycles after accept, n = alignment shifts.
// Backpressure: exercises out_ready held low in DONE and reset aborting an operation.
module tb_fpu_uni_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        din_uni_y_sgn = 1'b0;
  logic [5:0]  din_uni_y_exp = 6'd0;
  logic [21:0] din_uni_y_man_dn = 22'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout_h;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;

  fpu_uni_pack dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .din_uni_y_sgn    (din_uni_y_sgn),
    .din_uni_y_exp    (din_uni_y_exp),
    .din_uni_y_man_dn (din_uni_y_man_dn),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .dout_h           (dout_h),
    .flag_ovf         (flag_ovf),
    .flag_unf         (flag_unf),
    .flag_inx         (flag_inx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] h;
    logic [2:0]  fl;   // {ovf, unf, inx}
    int          acc;
    int          n;
  } exp_t;

  exp_t expq[$];

  // Directed vectors with hand-computed results: {ovf,unf,inx} and shift count n.
  localparam int NV = 14;
  logic        vs  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          veu [NV] = '{31, 33, 31, 31, 50, 16, 20, 31, 16, 3, 40, 18, 46, 46};
  int          vman[NV] = '{32'h200000, 32'h080000, 32'h200400, 32'h200C00, 32'h200000,
                            32'h200000, 32'h000000, 32'h3FFFFF, 32'h3FF800, 32'h123456,
                            32'h000001, 32'h040000, 32'h3FFFFF, 32'h3FF800};
  logic [15:0] vh  [NV] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C02, 16'h7C00, 16'h0200,
                            16'h8000, 16'hC000, 16'h0400, 16'h0000, 16'h0C00, 16'h0100,
                            16'h7C00, 16'h7BFF};
  logic [2:0]  vfl [NV] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b000, 3'b000,
                            3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 3'b101, 3'b000};
  int          vn  [NV] = '{0, 2, 0, 0, 0, 1, 0, 0, 1, 0, 21, 1, 0, 0};

  // Value-level model: value = man * 2^(e_u-52); quantise to the binary16 grid with RNE.
  function automatic void model(input logic sgn, input int eu, input int man,
                                output logic [15:0] bits, output logic [2:0] fl,
                                output int n);
    int     p;
    int     be;
    int     k;
    int     s;
    int     ee;
    int     code;
    longint q;
    longint rem;
    longint half;
    logic   up;
    logic   ovf;
    logic   unf;
    logic   inx;
    if (man == 0) begin
      bits = {sgn, 15'h0000};
      fl   = 3'b000;
      n    = 0;
      return;
    end
    p = 0;
    for (int i = 0; i < 22; i++) if (((man >> i) & 1) != 0) p = i;
    be = p + eu - 37;
    k  = (be < 1) ? (eu - 28) : (10 - p);
    if (k >= 0) begin
      q   = longint'(man) << k;
      rem = 0;
      up  = 1'b0;
    end else begin
      s    = -k;
      if (s > 40) s = 40;
      q    = longint'(man) >> s;
      rem  = longint'(man) & ((64'd1 << s) - 1);
      half = 64'd1 << (s - 1);
      up   = (rem > half) || ((rem == half) && (q[0] == 1'b1));
    end
    q    = q + (up ? 1 : 0);
    code = (be < 1) ? int'(q) : ((be - 1) * 1024 + int'(q));
    inx  = (rem != 0);
    unf  = (be < 1) && inx;
    ovf  = 1'b0;
    if (code >= 32'h7C00) begin
      ovf  = 1'b1;
      inx  = 1'b1;
      bits = {sgn, 15'h7C00};
    end else begin
      bits = {sgn, code[14:0]};
    end
    fl = {ovf, unf, inx};
    ee = eu - 16;
    if (ee < -11)     n = 0;
    else if (ee < 1)  n = 1 - ee;
    else              n = ((21 - p) < (ee - 1)) ? (21 - p) : (ee - 1);
  endfunction

  // Output monitor: every cycle out_valid is high, compare against the oldest expected result.
  logic seen = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      seen = 1'b0;
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out_valid: out_valid=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        cur = expq[0];
        if (!seen) begin
          seen = 1'b1;
          tests++;
          if (cyc - cur.acc != 3 + cur.n) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc - cur.acc, 3 + cur.n);
          end
        end
        tests++;
        if ({dout_h, flag_ovf, flag_unf, flag_inx} !== {cur.h, cur.fl}) begin
          fails++;
          $display("FAIL result: dout_h=%h flags(ovf,unf,inx)=%b, expected %h %b",
                   dout_h, {flag_ovf, flag_unf, flag_inx}, cur.h, cur.fl);
        end
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL in_ready_in_done: in_ready=%b, expected 0", in_ready);
        end
        if (out_ready) begin
          void'(expq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Present vector idx; returns the cycle of acceptance. Called at a negedge.
  task automatic drive(input int idx, output int acc);
    int   t;
    exp_t x;
    in_valid         = 1'b1;
    din_uni_y_sgn    = vs[idx];
    din_uni_y_exp    = veu[idx][5:0];
    din_uni_y_man_dn = vman[idx][21:0];
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
      return;
    end
    model(vs[idx], veu[idx], vman[idx], x.h, x.fl, x.n);
    x.acc = cyc;
    expq.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial begin
    logic [15:0] mh;
    logic [2:0]  mfl;
    int          mn;
    int          a0;
    int          a1;
    int          t;
    int          nvalid;

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("rst_dout_h", {16'd0, dout_h}, 32'd0);
    check1("rst_flags", {29'd0, flag_ovf, flag_unf, flag_inx}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check1("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Pin the model to the hand-computed table.
    for (int i = 0; i < NV; i++) begin
      model(vs[i], veu[i], vman[i], mh, mfl, mn);
      tests++;
      if (mh !== vh[i] || mfl !== vfl[i] || mn != vn[i]) begin
        fails++;
        $display("FAIL model_vec%0d: h=%h fl=%b n=%0d, expected h=%h fl=%b n=%0d",
                 i, mh, mfl, mn, vh[i], vfl[i], vn[i]);
      end
    end

    // Each vector through the DUT, consumer always ready.
    for (int i = 0; i < NV; i++) begin
      drive(i, a0);
      wait_empty();
    end

    // Back-to-back accepts with out_ready high are 4 cycles apart.
    drive(0, a0);
    drive(3, a1);
    wait_empty();
    check1("accept_spacing", a1 - a0, 32'd4);

    // Consumer stalls 10 cycles in DONE; monitor checks stability and in_ready each cycle.
    out_ready = 1'b0;
    drive(4, a0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check1("stall_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    check1("stall_dout_h", {16'd0, dout_h}, 32'h7C00);
    out_ready = 1'b1;
    wait_empty();

    // Reset in the middle of a 21-shift alignment.
    drive(10, a0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check1("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check1("in_ready_after_midrst", {31'd0, in_ready}, 32'd1);
    nvalid = 0;
    repeat (40) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
    check1("aborted_no_output", nvalid, 32'd0);

    // Recovery after the aborted operation.
    drive(7, a0);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_uni_pack.md
FPU_UNI_PACK -- requirements
Module: fpu_uni_pack

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  unified operand present.
REQ-005 in_ready  out  1  block can accept; high only in IDLE.
REQ-006 din_uni_y_sgn  in  1  sign of the FPALU result.
REQ-007 din_uni_y_exp  in  6  unified exponent e_u, unsigned, bias 31.
REQ-008 din_uni_y_man_dn  in  22  left-aligned, possibly denormalized mantissa; bit21 weight 2^0.
REQ-009 out_valid  out  1  packed result valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 dout_h  out  16  IEEE-754 binary16 result.
REQ-012 flag_ovf / flag_unf / flag_inx  out  1 each  overflow, underflow (tiny and inexact), inexact.

Function
REQ-013 Value of input = (-1)^sgn * man*2^-21 * 2^(e_u-31); internal signed 8-bit E = e_u - 16, the binary16-biased exponent.
REQ-014 FSM states IDLE, ALIGN, ROUND, DONE; transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 On accept: latch sgn, man into 22-bit M, E; clear sticky S.
REQ-016 On accept with man==0: M=0, E=1, S=0.
REQ-017 On accept with man!=0 and E < -11: M=0, S=1, E=1.
REQ-018 ALIGN, one action per cycle, in priority order: if E<1, right shift M by 1 and OR the shifted-out bit into S, E++.
REQ-019 Otherwise, if M!=0 && M[21]==0 && E>1, left shift M by 1, E--.
REQ-020 Otherwise, go to ROUND.
REQ-021 ROUND: f=M[21:11], guard G=M[10], sticky T=S|(|M[9:0]); round-to-nearest-even, increment f when G && (T || f[0]).
REQ-022 After increment, if f==12'h800: f=11'h400, E++.
REQ-023 Exponent field = (f[10]==0) ? 0 : E.
REQ-024 If the field is >=31: dout_h = {sgn,5'h1F,10'h0}, flag_ovf=1, flag_inx=1.
REQ-025 Otherwise dout_h = {sgn,field,f[9:0]}.
REQ-026 flag_inx = G|T; flag_unf = (pre-round M[21]==0) && flag_inx; sign preserved for zero results.
REQ-027 ROUND registers dout_h and flags, then goes to DONE.
REQ-028 DONE asserts out_valid; output held stable until out_ready; IDLE on transfer.
REQ-029 in_ready is low in ALIGN, ROUND and DONE; no input skid or bypass.
REQ-030 Latency from accept edge to out_valid = 3 + n cycles, n = number of shift cycles; max n = 21.
REQ-031 Consecutive accepts are at least 4 cycles apart; out_ready held high gives DONE→IDLE in 1 cycle.

Reset
REQ-032 rst asserted, any state, including mid-ALIGN or in DONE with out_ready low: FSM→IDLE immediately.
REQ-033 Reset values: out_valid=0, dout_h=0, all flags 0, M=0, E=0, S=0.
REQ-034 in_ready=1 the first cycle after rst deasserts; the aborted operation produces no output.

Verification
REQ-035 e_u=31, man=0x200000, sgn=0, out_ready=1 -> dout_h=0x3C00, flags 0, out_valid exactly 3 cycles after accept.
REQ-036 e_u=33, man=0x080000 -> 2 left shifts, dout_h=0x3C00, out_valid 5 cycles after accept.
REQ-037 e_u=31, man=0x200400 -> tie, even LSB, dout_h=0x3C00, inx=1; man=0x200C00 -> dout_h=0x3C02, inx=1.
REQ-038 e_u=50, man=0x200000 -> dout_h=0x7C00, ovf=1, inx=1.
REQ-039 e_u=16, man=0x200000 -> dout_h=0x0200, unf=0, inx=0; sgn=1, man=0 -> dout_h=0x8000.
REQ-040 out_ready low 10 cycles in DONE: dout_h stable and in_ready=0 throughout; rst pulse mid-ALIGN -> out_valid never asserts, in_ready=1 next cycle.
